keypad_scan_queue: RTL and testbench
====================================

// Module: keypad_scan_queue
// PURPOSE
//  Parametrised matrix-keypad scanner: drives one row at a time and samples the column inputs.
//  Debounces every key independently and queues press events in a FIFO with a valid/ready handshake.
//  Successor to the fixed 4x4 keypad controller: row/column counts, scan rate, debounce depth and queue depth are configurable.
//  Sits between the keypad pins and the game control logic; runs on the system clock.
// PARAMETERS
//  ROWS        4    number of keypad rows driven (>=1)
//  COLS        4    number of keypad columns sampled (>=1)
//  SCAN_DIV    500  clock cycles per row dwell (>= COLS+2)
//  DEBOUNCE    3    consecutive identical samples required to change a key's state (>=1)
//  FIFO_DEPTH  4    event queue entries (power of 2, >=2)
// PORTS
//  clock          in   1            system clock
//  reset          in   1            asynchronous, active-low reset
//  keyPad_col     in   COLS         column sense, active-low (0 = key pressed in driven row)
//  keyPad_row     out  ROWS         row drive, one-hot active-low
//  key_valid      out  1            queue head holds an event
//  key_code       out  CW           head key index = row*COLS+col; CW = clog2(ROWS*COLS)
//  key_ready      in   1            consumer accepts the head this cycle
//  key_pressed    out  ROWS*COLS    debounced level of every key; bit i = key index i
//  overflow       out  1            sticky: a press event was dropped
//  clear_overflow in   1            synchronous clear of overflow
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - row index = 0; keyPad_row = ~1 (row 0 driven)
//   - prescaler = 0; FIFO empty; key_valid = 0; key_code = 0
//   - key_pressed = 0; overflow = 0; all debounce counters and pending masks = 0
//  Scan:
//   - prescaler counts 0..SCAN_DIV-1; "tick" = cycle where prescaler == SCAN_DIV-1
//   - on tick, sample ~keyPad_col for the current row, then advance the row index (ROWS-1 wraps to 0)
//   - keyPad_row changes the cycle after the tick
//   - each key is sampled once per ROWS*SCAN_DIV cycles
//  Debounce (per key, updated only at its row's tick):
//   - raw == key_pressed[i]: counter := 0
//   - raw != key_pressed[i]: counter += 1; when counter reaches DEBOUNCE, toggle key_pressed[i] and set counter := 0
//   - DEBOUNCE=1: a key toggles on its first differing sample
//  Event generation:
//   - 0->1 transitions of the current row at the tick are OR-ed into a pending column mask
//   - one event per cycle is pushed, lowest column first, starting the cycle after the tick
//   - the mask drains before the next tick (guaranteed by SCAN_DIV >= COLS+2)
//   - 1->0 transitions (releases) are never queued
//  FIFO / handshake:
//   - key_valid = !empty; key_code = head entry (0 when empty); both registered
//   - pop when key_valid && key_ready; key_code holds stable while key_valid && !key_ready
//   - a push is visible on key_valid the cycle after the push
//   - push while full with no pop: event dropped, overflow := 1
//   - push and pop in the same cycle while full: both happen, no overflow
//   - key_ready while empty: ignored
//  Overflow:
//   - clear_overflow clears overflow
//   - clear_overflow and a drop in the same cycle: overflow stays 1 (set wins)
//  Reset mid-operation: queued events, pending masks and debounce progress are discarded; no event is emitted on release of reset.
// TESTING
//  1. Defaults (SCAN_DIV=8 in sim), hold key 6 (row1,col2) low for 4 scans -> key_pressed[6]=1 at row1's 3rd sample tick; key_valid=1, key_code=6 two cycles after that tick.
//  2. Key 6 glitch: low for 2 samples, then high -> no event; key_pressed[6] stays 0; debounce counter returns to 0.
//  3. Keys 4 and 7 pressed together (same row) -> events 4 then 7 on consecutive cycles; queue order 4, 7.
//  4. key_ready=0, press 5 distinct keys -> first 4 queued, 5th dropped, overflow=1; drain -> codes in press order; clear_overflow -> overflow=0.
//  5. Full queue, key_ready=1 during a push -> head popped, new code enqueued, overflow stays 0.
//  6. Reset asserted mid-debounce with 2 events queued -> key_valid=0, keyPad_row=4'b1110 immediately; no events after release until a fresh debounced press.

Source files
------------

// File: rtl/keypad_scan_queue.sv
// ---------------------------------------------------------------------------
// keypad_scan_queue
//
// Matrix-keypad scanner with per-key debounce and a press-event queue.
// One row is driven low at a time for SCAN_DIV clocks. At the last clock of
// that dwell (the "tick") the active-low column inputs are sampled for the
// driven row, and then the next row is selected. Every key has its own
// debounce counter. A debounced 0->1 transition becomes a press event.
// Press events go into a small FIFO that the consumer drains with a
// valid/ready handshake. Releases are tracked in key_pressed but are never
// queued.
//
// Ports
//   clock          in   system clock
//   reset          in   asynchronous, active-low reset
//   keyPad_col     in   [COLS-1:0]  column sense, active-low
//   keyPad_row     out  [ROWS-1:0]  row drive, one-hot active-low
//   key_valid      out  queue head holds an event
//   key_code       out  [CW-1:0]    head key index (row*COLS+col), 0 when empty
//   key_ready      in   consumer accepts the head this cycle
//   key_pressed    out  [ROWS*COLS-1:0] debounced level of every key
//   overflow       out  sticky flag: a press event was dropped
//   clear_overflow in   synchronous clear of overflow
//
// Handshake: key_valid/key_code come straight from registers. The head is
// consumed on any clock edge where key_valid && key_ready. While key_valid is
// high and key_ready is low, key_code holds its value. key_ready is ignored
// while the queue is empty. A pushed event appears on key_valid the cycle
// after the push.
// ---------------------------------------------------------------------------
module keypad_scan_queue #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 500,
  parameter int DEBOUNCE   = 3,
  parameter int FIFO_DEPTH = 4,
  localparam int KEYS      = ROWS * COLS,
  localparam int CW        = (KEYS > 1) ? $clog2(KEYS) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [COLS-1:0] keyPad_col,
  output logic [ROWS-1:0] keyPad_row,
  output logic            key_valid,
  output logic [CW-1:0]   key_code,
  input  logic            key_ready,
  output logic [KEYS-1:0] key_pressed,
  output logic            overflow,
  input  logic            clear_overflow
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  // -------------------------------------------------------------------------
  // Row scan: prescaler and row select
  // -------------------------------------------------------------------------
  logic [PW-1:0]   prescaler;
  logic            tick;
  logic [RW-1:0]   row_idx;
  logic [RW-1:0]   row_next;
  logic [ROWS-1:0] row_drive;

  assign tick       = (prescaler == PW'(SCAN_DIV - 1));
  assign row_next   = (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + RW'(1);
  assign keyPad_row = row_drive;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prescaler <= '0;
      row_idx   <= '0;
      row_drive <= ~ROWS'(1);
    end else if (tick) begin
      prescaler <= '0;
      row_idx   <= row_next;
      // The drive is registered alongside row_idx, so the pins move on the
      // cycle after the tick. The current row is sampled on the tick first.
      row_drive <= ~(ROWS'(1) << row_next);
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Per-key debounce. Only the keys of the driven row change, and only on
  // the tick.
  // -------------------------------------------------------------------------
  logic [COLS-1:0] raw;
  logic [DW-1:0]   cnt      [KEYS];
  logic [DW-1:0]   cnt_next [KEYS];
  logic [KEYS-1:0] pressed_next;
  logic [COLS-1:0] rise;

  assign raw = ~keyPad_col;

  always_comb begin
    int base;
    int k;
    base         = int'(row_idx) * COLS;
    k            = 0;
    pressed_next = key_pressed;
    cnt_next     = cnt;
    rise         = '0;
    if (tick) begin
      for (int c = 0; c < COLS; c++) begin
        k = base + c;
        if (raw[c] == key_pressed[k]) begin
          // A sample that agrees with the debounced level cancels any
          // progress toward a toggle.
          cnt_next[k] = '0;
        end else if (cnt[k] == DW'(DEBOUNCE - 1)) begin
          cnt_next[k]     = '0;
          pressed_next[k] = ~key_pressed[k];
          rise[c]         = raw[c];
        end else begin
          cnt_next[k] = cnt[k] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_pressed <= '0;
      for (int i = 0; i < KEYS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      key_pressed <= pressed_next;
      cnt         <= cnt_next;
    end
  end

  // -------------------------------------------------------------------------
  // Event generation. New presses of the sampled row are parked in a column
  // mask together with that row's index, because row_idx has already moved
  // on. The mask is drained one column per cycle, lowest column first. The
  // minimum dwell of COLS+2 clocks empties the mask before the next tick.
  // -------------------------------------------------------------------------
  logic [COLS-1:0] pend;
  logic [COLS-1:0] pend_low;
  logic [RW-1:0]   pend_row;
  logic            push;
  logic [CW-1:0]   push_code;

  assign push     = |pend;
  assign pend_low = pend & (~pend + COLS'(1));

  always_comb begin
    int col_sel;
    col_sel = 0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (pend[c]) begin
        col_sel = c;
      end
    end
    push_code = CW'(int'(pend_row) * COLS + col_sel);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend     <= '0;
      pend_row <= '0;
    end else if (tick) begin
      pend     <= rise;
      pend_row <= row_idx;
    end else begin
      pend     <= pend & ~pend_low;
    end
  end

  // -------------------------------------------------------------------------
  // Event FIFO. When the queue is full, a push and a pop on the same edge
  // both happen. The new entry lands in the slot being freed.
  // -------------------------------------------------------------------------
  logic [CW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          pop;
  logic          do_push;
  logic          drop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign pop     = !empty && key_ready;
  assign do_push = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_code;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + (AW+1)'(do_push) - (AW+1)'(pop);
    end
  end

  assign key_valid = !empty;
  assign key_code  = empty ? '0 : mem[rd_ptr];

  // -------------------------------------------------------------------------
  // Sticky overflow. A drop in the same cycle as a clear leaves the flag set.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scan_queue.sv
// ---------------------------------------------------------------------------
// tb_keypad_scan_queue
//
// Directed bench for keypad_scan_queue with a 4x4 matrix, SCAN_DIV=8,
// DEBOUNCE=3 and FIFO_DEPTH=4. A behavioural keypad model pulls a column low
// whenever a held key sits in the currently driven row. Timing is tracked
// from the bench's own edge counter, taken relative to reset release. With
// that counter, row r is sampled on release-relative edges 8*(r+1) mod 32.
// ---------------------------------------------------------------------------
module tb_keypad_scan_queue;

  localparam int SCAN   = 8;
  localparam int FRAME  = 4 * SCAN;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  keyPad_col;
  logic [3:0]  keyPad_row;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready = 1'b0;
  logic [15:0] key_pressed;
  logic        overflow;
  logic        clear_overflow = 1'b0;

  logic [15:0] held = '0;
  int          edges = 0;
  int          rel_mark = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [3:0]  exp_q[$];

  keypad_scan_queue #(
    .ROWS(4), .COLS(4), .SCAN_DIV(SCAN), .DEBOUNCE(3), .FIFO_DEPTH(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .keyPad_col(keyPad_col),
    .keyPad_row(keyPad_row),
    .key_valid(key_valid),
    .key_code(key_code),
    .key_ready(key_ready),
    .key_pressed(key_pressed),
    .overflow(overflow),
    .clear_overflow(clear_overflow)
  );

  // ---- clock / reset block ----
  always #5 clock = ~clock;
  always @(posedge clock) edges <= edges + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---- keypad model ----
  always_comb begin
    keyPad_col = '1;
    for (int r = 0; r < 4; r++) begin
      if (!keyPad_row[r]) begin
        for (int c = 0; c < 4; c++) begin
          if (held[r*4+c]) keyPad_col[c] = 1'b0;
        end
      end
    end
  end

  // ---- driver tasks ----
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next sampling edge of the given row.
  task automatic goto_tick(input int row);
    int  target;
    bit  hit;
    target = (SCAN * (row + 1)) % FRAME;
    hit    = 1'b0;
    for (int k = 0; k < FRAME + 8 && !hit; k++) begin
      step();
      if ((edges - rel_mark) % FRAME == target) hit = 1'b1;
    end
    if (!hit) check("goto_tick_timeout", 32'd0, 32'd1);
  endtask

  // ---- scoreboard drain ----
  task automatic drain(input string tag);
    logic [3:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, 32'(key_valid), 32'd1);
      check({tag, "_code"}, 32'(key_code), 32'(e));
      key_ready = 1'b1;
      step();
      key_ready = 1'b0;
    end
    check({tag, "_empty"}, 32'(key_valid), 32'd0);
  endtask

  // ---- vector table ----
  typedef struct {
    logic [15:0] held;
    int          row;     // -1: no tick wait
    int          post;    // extra clocks after the tick
    logic        ready;
    logic [15:0] exp_pressed;
    logic        exp_valid;
    logic [3:0]  exp_code;
    logic        exp_ovf;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [15:0] h, input int row, input int post,
                              input logic rdy, input logic [15:0] p, input logic v,
                              input logic [3:0] code, input logic o);
    vec_t t;
    t.held = h; t.row = row; t.post = post; t.ready = rdy;
    t.exp_pressed = p; t.exp_valid = v; t.exp_code = code; t.exp_ovf = o;
    return t;
  endfunction

  initial begin
    // Key 6 pressed: toggles on the third row-1 sample, event 2 cycles later.
    vecs[0]  = mk(16'h0040,  1, 0, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b0);
    vecs[1]  = mk(16'h0040,  1, 0, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b0);
    vecs[2]  = mk(16'h0040,  1, 0, 1'b0, 16'h0040, 1'b0, 4'd0, 1'b0);
    vecs[3]  = mk(16'h0040, -1, 1, 1'b0, 16'h0040, 1'b1, 4'd6, 1'b0);
    vecs[4]  = mk(16'h0040, -1, 1, 1'b1, 16'h0040, 1'b0, 4'd0, 1'b0);
    // Release of key 6: level drops after 3 samples, nothing queued.
    vecs[5]  = mk(16'h0000,  1, 0, 1'b1, 16'h0040, 1'b0, 4'd0, 1'b0);
    vecs[6]  = mk(16'h0000,  1, 0, 1'b1, 16'h0040, 1'b0, 4'd0, 1'b0);
    vecs[7]  = mk(16'h0000,  1, 2, 1'b1, 16'h0000, 1'b0, 4'd0, 1'b0);
    // Glitch: two low samples, one high, then two low again -> never toggles.
    vecs[8]  = mk(16'h0040,  1, 0, 1'b1, 16'h0000, 1'b0, 4'd0, 1'b0);
    vecs[9]  = mk(16'h0040,  1, 0, 1'b1, 16'h0000, 1'b0, 4'd0, 1'b0);
    vecs[10] = mk(16'h0000,  1, 0, 1'b1, 16'h0000, 1'b0, 4'd0, 1'b0);
    vecs[11] = mk(16'h0040,  1, 0, 1'b1, 16'h0000, 1'b0, 4'd0, 1'b0);
    vecs[12] = mk(16'h0040,  1, 2, 1'b1, 16'h0000, 1'b0, 4'd0, 1'b0);
    vecs[13] = mk(16'h0000,  1, 0, 1'b1, 16'h0000, 1'b0, 4'd0, 1'b0);
    // Keys 4 and 7 together: pushed on consecutive cycles, 4 first.
    vecs[14] = mk(16'h0090,  1, 0, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b0);
    vecs[15] = mk(16'h0090,  1, 0, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b0);
    vecs[16] = mk(16'h0090,  1, 0, 1'b0, 16'h0090, 1'b0, 4'd0, 1'b0);
    vecs[17] = mk(16'h0090, -1, 1, 1'b0, 16'h0090, 1'b1, 4'd4, 1'b0);
    vecs[18] = mk(16'h0090, -1, 1, 1'b0, 16'h0090, 1'b1, 4'd4, 1'b0);
    vecs[19] = mk(16'h0090, -1, 1, 1'b1, 16'h0090, 1'b1, 4'd7, 1'b0);
    vecs[20] = mk(16'h0090, -1, 1, 1'b1, 16'h0090, 1'b0, 4'd0, 1'b0);
    vecs[21] = mk(16'h0000,  1, 0, 1'b1, 16'h0090, 1'b0, 4'd0, 1'b0);
    vecs[22] = mk(16'h0000,  1, 0, 1'b1, 16'h0090, 1'b0, 4'd0, 1'b0);
    vecs[23] = mk(16'h0000,  1, 0, 1'b1, 16'h0000, 1'b0, 4'd0, 1'b0);

    // ---- reset state ----
    step(); step();
    check("rst_row",     32'(keyPad_row),  32'h0000000e);
    check("rst_valid",   32'(key_valid),   32'd0);
    check("rst_code",    32'(key_code),    32'd0);
    check("rst_pressed", 32'(key_pressed), 32'd0);
    check("rst_ovf",     32'(overflow),    32'd0);
    reset = 1'b1;
    rel_mark = edges;

    // Row drive moves only on the cycle after the first tick.
    repeat (SCAN - 1) step();
    check("row_before_tick", 32'(keyPad_row), 32'h0000000e);
    step();
    check("row_after_tick",  32'(keyPad_row), 32'h0000000d);

    // ---- table-driven vectors ----
    for (int i = 0; i < NV; i++) begin
      held      = vecs[i].held;
      key_ready = vecs[i].ready;
      if (vecs[i].row >= 0) goto_tick(vecs[i].row);
      repeat (vecs[i].post) step();
      check($sformatf("vec%0d_pressed", i), 32'(key_pressed), 32'(vecs[i].exp_pressed));
      check($sformatf("vec%0d_valid", i),   32'(key_valid),   32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_code", i),    32'(key_code),    32'(vecs[i].exp_code));
      check($sformatf("vec%0d_ovf", i),     32'(overflow),    32'(vecs[i].exp_ovf));
    end

    // ---- overflow: 5 presses into a 4-deep queue, consumer stalled ----
    key_ready = 1'b0;
    held = 16'h0000;
    goto_tick(3);
    held = 16'h8429;              // keys 0,3 (row0), 5, 10, 15
    repeat (3) goto_tick(3);
    step(); step();
    check("ovf_pressed", 32'(key_pressed), 32'h00008429);
    check("ovf_set",     32'(overflow),    32'd1);
    exp_q = '{4'd0, 4'd3, 4'd5, 4'd10};
    drain("ovf_drain");
    check("ovf_sticky", 32'(overflow), 32'd1);
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // ---- full queue with a pop on the same edge as a push ----
    held = 16'h0000;
    repeat (4) goto_tick(3);
    check("rel_all_pressed", 32'(key_pressed), 32'd0);
    held = 16'h001f;              // keys 0..3 (row0), key 4 (row1)
    repeat (3) goto_tick(0);
    goto_tick(1);
    check("full_head", 32'(key_code), 32'd0);
    key_ready = 1'b1;
    step();
    key_ready = 1'b0;
    check("pushpop_code", 32'(key_code), 32'd1);
    check("pushpop_ovf",  32'(overflow), 32'd0);
    exp_q = '{4'd1, 4'd2, 4'd3, 4'd4};
    drain("pushpop_drain");
    check("pushpop_ovf_end", 32'(overflow), 32'd0);

    // ---- reset mid-operation ----
    held = 16'h0000;
    repeat (4) goto_tick(3);
    held = 16'h0203;              // keys 0,1 (row0), key 9 (row2)
    repeat (3) goto_tick(0);
    step(); step();
    check("pre_rst_valid", 32'(key_valid), 32'd1);
    check("pre_rst_code",  32'(key_code),  32'd0);
    reset = 1'b0;
    #1;
    check("mid_rst_valid",   32'(key_valid),   32'd0);
    check("mid_rst_row",     32'(keyPad_row),  32'h0000000e);
    check("mid_rst_pressed", 32'(key_pressed), 32'd0);
    step(); step();
    reset = 1'b1;
    rel_mark = edges;
    repeat (2) goto_tick(0);
    step(); step();
    check("post_rst_valid",   32'(key_valid),   32'd0);
    check("post_rst_pressed", 32'(key_pressed), 32'd0);
    goto_tick(0);
    step();
    check("fresh_valid",   32'(key_valid),   32'd1);
    check("fresh_code",    32'(key_code),    32'd0);
    check("fresh_pressed", 32'(key_pressed), 32'h00000003);
    goto_tick(2);
    step(); step();
    check("fresh_pressed9", 32'(key_pressed), 32'h00000203);
    exp_q = '{4'd0, 4'd1, 4'd9};
    drain("fresh_drain");

    // ---- final report ----
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
